// File: rtl/ram_bist_sequencer_if.sv
// Bundle of the control, status and RAM-side signals of the BIST sequencer.
// The slave modport is the sequencer itself. The master modport is the
// environment around it: the lab top level plus the RAM.
interface ram_bist_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic              start;
  logic [1:0]        pattern_sel;
  logic [DATA_W-1:0] ram_data_out;
  logic [DATA_W-1:0] ram_data_in;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_cs;
  logic              ram_rw;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] first_err_addr;

  modport master (
    output start, pattern_sel, ram_data_out,
    input  ram_data_in, ram_address, ram_cs, ram_rw,
    input  busy, done, pass, err_count, first_err_addr
  );

  modport slave (
    input  start, pattern_sel, ram_data_out,
    output ram_data_in, ram_address, ram_cs, ram_rw,
    output busy, done, pass, err_count, first_err_addr
  );
endinterface

// File: rtl/ram_bist_sequencer.sv
// RAM BIST sequencer.
// The sequencer writes a selected pattern to every RAM location. It then
// reads each location back and compares it with the pattern, counting the
// mismatches and capturing the first failing address.
module ram_bist_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  ram_bist_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RD_CHK  = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [1:0]        WAIT_INIT = 2'(READ_LAT - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        pat_q;
  logic [1:0]        wait_q;
  logic [ADDR_W:0]   err_q;
  logic [ADDR_W-1:0] first_q;
  logic              cs_q;
  logic              rw_q;
  logic [DATA_W-1:0] din_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              mismatch;

  // Expected contents of a location for a given pattern.
  function automatic logic [DATA_W-1:0] exp_data(input logic [1:0] sel,
                                                 input logic [ADDR_W-1:0] a);
    case (sel)
      2'd0:    return '0;
      2'd1:    return '1;
      2'd2:    return a[0] ? {(DATA_W/2){2'b10}} : {(DATA_W/2){2'b01}};
      default: return DATA_W'(a);
    endcase
  endfunction

  // The comparison only feeds state updates and never reaches an output directly.
  assign mismatch = (bus.ram_data_out != exp_data(pat_q, addr_q));

  // Sequencer FSM. Every RAM-side and status output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      pat_q   <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      cs_q    <= 1'b0;
      rw_q    <= 1'b0;
      din_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            pat_q   <= bus.pattern_sel;
            addr_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            cs_q    <= 1'b1;
            rw_q    <= 1'b1;
            din_q   <= exp_data(bus.pattern_sel, '0);
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (addr_q == LAST_ADDR) begin
            // The write phase ends here. Reads restart from address 0.
            addr_q  <= '0;
            rw_q    <= 1'b0;
            din_q   <= '0;
            state_q <= RD_REQ;
          end else begin
            addr_q <= addr_q + 1'b1;
            din_q  <= exp_data(pat_q, addr_q + 1'b1);
          end
        end
        RD_REQ: begin
          if (READ_LAT > 1) begin
            wait_q  <= WAIT_INIT;
            state_q <= RD_WAIT;
          end else begin
            state_q <= RD_CHK;
          end
        end
        RD_WAIT: begin
          if (wait_q <= 2'd1) state_q <= RD_CHK;
          else                wait_q  <= wait_q - 1'b1;
        end
        RD_CHK: begin
          if (mismatch) begin
            if (err_q == '0) first_q <= addr_q;
            err_q <= err_q + 1'b1;
          end
          if (addr_q == LAST_ADDR) begin
            addr_q  <= '0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_q == '0) && !mismatch;
            state_q <= DONE;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= RD_REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_cs         = cs_q;
  assign bus.ram_rw         = rw_q;
  assign bus.ram_address    = addr_q;
  assign bus.ram_data_in    = din_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_err_addr = first_q;

endmodule

// File: tb/tb_ram_bist_sequencer.sv
// Testbench for ram_bist_sequencer.
// A behavioural 64x8 RAM with injectable faults sits on the bus.
// RAM transactions are compared against a queue of expected accesses.
module tb_ram_bist_sequencer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  ram_bist_sequencer_if bus ();

  ram_bist_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, one-cycle synchronous read, read-side faults.
  logic [7:0] mem [64];
  logic [7:0] rd_q;
  logic [5:0] rd_a_q;
  bit         f_stuck1;
  bit         f_bit7;

  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_rw) begin
        mem[bus.ram_address] <= bus.ram_data_in;
      end else begin
        rd_q   <= mem[bus.ram_address];
        rd_a_q <= bus.ram_address;
      end
    end
  end

  always_comb begin
    bus.ram_data_out = rd_q;
    if (f_stuck1 && (rd_a_q == 6'd5 || rd_a_q == 6'd40)) bus.ram_data_out[0] = 1'b1;
    if (f_bit7) bus.ram_data_out[7] = 1'b0;
  end

  typedef struct {
    logic [5:0] a;
    logic [7:0] d;
  } wtx_t;

  function automatic logic [7:0] exp_data(input logic [1:0] p, input logic [5:0] a);
    case (p)
      2'd0:    return 8'h00;
      2'd1:    return 8'hFF;
      2'd2:    return a[0] ? 8'hAA : 8'h55;
      default: return {2'b00, a};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    total++;
    bad++;
    $error("FAIL %s observed=unexpected bus access expected=none", tag);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_cs"},    bus.ram_cs, 0);
    chk({pfx, "_rw"},    bus.ram_rw, 0);
    chk({pfx, "_addr"},  bus.ram_address, 0);
    chk({pfx, "_din"},   bus.ram_data_in, 0);
    chk({pfx, "_busy"},  bus.busy, 0);
    chk({pfx, "_done"},  bus.done, 0);
    chk({pfx, "_pass"},  bus.pass, 0);
    chk({pfx, "_err"},   bus.err_count, 0);
    chk({pfx, "_first"}, bus.first_err_addr, 0);
  endtask

  // One full test. The start edge is N, and c counts edges after N.
  // Each sample is taken #1 after edge N+c. done registered at N+192 is the
  // done that edge N+193 observes.
  task automatic run_test(input logic [1:0] pat, input int exp_err, input int exp_first,
                          input bit restart10, input bit rst30);
    wtx_t       wq[$];
    logic [5:0] rq[$];
    wtx_t       w;
    logic [5:0] ra;
    int         c;
    bit         prev_rd;
    logic [5:0] prev_a;
    for (int k = 0; k < 64; k++) begin
      wq.push_back('{6'(k), exp_data(pat, 6'(k))});
      rq.push_back(6'(k));
    end
    bus.start = 1'b1;
    bus.pattern_sel = pat;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.pattern_sel = ~pat;
    chk("start_busy", bus.busy, 1);
    chk("start_done_clr", bus.done, 0);
    chk("start_pass_clr", bus.pass, 0);
    chk("start_err_clr", bus.err_count, 0);
    c = 0;
    prev_rd = 1'b0;
    prev_a = '0;
    while (c < 400 && !bus.done) begin
      if (bus.ram_cs && bus.ram_rw) begin
        if (wq.size() == 0) fail_now("wr_extra");
        else begin
          w = wq.pop_front();
          chk("wr_addr", bus.ram_address, w.a);
          chk("wr_data", bus.ram_data_in, w.d);
        end
      end
      if (bus.ram_cs && !bus.ram_rw && (!prev_rd || bus.ram_address != prev_a)) begin
        if (rq.size() == 0) fail_now("rd_extra");
        else begin
          ra = rq.pop_front();
          chk("rd_addr", bus.ram_address, ra);
        end
      end
      prev_rd = bus.ram_cs && !bus.ram_rw;
      prev_a  = bus.ram_address;
      if (restart10 && c == 9) bus.start = 1'b1;
      if (rst30 && c == 29) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_all_zero("midrst");
        return;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      c++;
    end
    chk("done_latency", c, 192);
    chk("done", bus.done, 1);
    chk("busy_end", bus.busy, 0);
    chk("cs_end", bus.ram_cs, 0);
    chk("rw_end", bus.ram_rw, 0);
    chk("pass", bus.pass, (exp_err == 0) ? 1 : 0);
    chk("err_count", bus.err_count, exp_err);
    chk("first_err_addr", bus.first_err_addr, exp_first);
    chk("writes_left", wq.size(), 0);
    chk("reads_left", rq.size(), 0);
    // A few idle cycles in DONE: the results must hold.
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", bus.done, 1);
    chk("err_hold", bus.err_count, exp_err);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    total = 0;
    bad = 0;
    f_stuck1 = 1'b0;
    f_bit7 = 1'b0;
    bus.start = 1'b0;
    bus.pattern_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", bus.busy, 0);

    // All zeros; a start pulse during the write phase must be ignored.
    run_test(2'd0, 0, 0, 1'b1, 1'b0);

    // Address pattern, started from DONE; RAM must hold k at location k.
    run_test(2'd3, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 64; k++) chk("mem_addr_pat", mem[k], k);

    // Rerun from DONE with pattern 0.
    run_test(2'd0, 0, 0, 1'b0, 1'b0);

    // Bit 0 stuck-at-1 at addresses 5 and 40, checkerboard.
    f_stuck1 = 1'b1;
    run_test(2'd2, 1, 5, 1'b0, 1'b0);
    f_stuck1 = 1'b0;

    // Data bit 7 stuck-at-0, all ones.
    f_bit7 = 1'b1;
    run_test(2'd1, 64, 0, 1'b0, 1'b0);
    f_bit7 = 1'b0;

    // Reset during write cycle 30, then a full clean run.
    run_test(2'd1, 0, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("post_rst_idle_busy", bus.busy, 0);
    run_test(2'd2, 0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
